// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Detects the start bit, deserializes
// DATA_WIDTH bits LSB-first, optionally checks parity, checks the stop bit and
// reports exactly one outcome per frame (Data_Valid, Par_Err or Stp_Err).
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling
// around mid-bit; without it a single mid-bit sample decides each bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q,    state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_typ_q,  par_typ_d;
    logic                  par_fail_q, par_fail_d;
    logic                  stop_bad_q, stop_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
    logic                  valid_q,    valid_d;
    logic                  par_err_q,  par_err_d;
    logic                  stp_err_q,  stp_err_d;
`ifdef UART_RX_MAJORITY_EN
    logic                  samp0_q,    samp0_d;
    logic                  samp1_q,    samp1_d;
`endif

    logic [5:0] half;
    logic       bit_end;
    logic       decide;
    logic       bit_val;

    // Next-state logic: bit timing, sampling, deserialization and frame outcome.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        half    = prescale_q >> 1;
        bit_end = (edge_cnt_q == prescale_q - 6'd1);
`ifdef UART_RX_MAJORITY_EN
        decide  = (edge_cnt_q == half + 6'd1);
        bit_val = (samp0_q & samp1_q) | (samp0_q & RX_IN) | (samp1_q & RX_IN);
        samp0_d = (edge_cnt_q == half - 6'd1) ? RX_IN : samp0_q;
        samp1_d = (edge_cnt_q == half)        ? RX_IN : samp1_q;
`else
        decide  = (edge_cnt_q == half);
        bit_val = RX_IN;
`endif
        state_d    = state_q;
        edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_fail_d = par_fail_q;
        stop_bad_d = stop_bad_q;
        p_data_d   = p_data_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                edge_cnt_d = 6'd0;
                if (!RX_IN) begin
                    // Detection cycle is edge 0 of the start bit; freeze frame config.
                    state_d    = START;
                    edge_cnt_d = 6'd1;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_fail_d = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            START: begin
                if (decide && bit_val) begin
                    state_d    = IDLE;
                    edge_cnt_d = 6'd0;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (decide) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (decide) par_fail_d = (bit_val != (^shift_q ^ par_typ_q));
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (decide) stop_bad_d = !bit_val;
                if (bit_end) begin
                    state_d = IDLE;
                    if (stop_bad_q)      stp_err_d = 1'b1;
                    else if (par_fail_q) par_err_d = 1'b1;
                    else begin
                        valid_d  = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register: all flops, including the data path, clear on reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            prescale_q <= 6'd8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
            stop_bad_q <= 1'b0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp0_q    <= 1'b1;
            samp1_q    <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop sees pre-edge values of the others.
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_fail_q <= par_fail_d;
            stop_bad_q <= stop_bad_d;
            p_data_q   <= p_data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
`ifdef UART_RX_MAJORITY_EN
            samp0_q    <= samp0_d;
            samp1_q    <= samp1_d;
`endif
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = valid_q;
    assign Par_Err    = par_err_q;
    assign Stp_Err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives UART frames cycle by cycle, predicts each frame's outcome
// and strobe cycle from the frame contents, and checks the DUT through a
// scoreboard monitor. Honors UART_RX_MAJORITY_EN for glitch expectations.
module tb_uart_rx;
    localparam int DW = 8;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b0;
    logic          RX_IN    = 1'b1;
    logic [5:0]    Prescale = 6'd8;
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stp_Err;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .Data_Valid(Data_Valid), .Par_Err(Par_Err), .Stp_Err(Stp_Err)
    );

    always #5 CLK = ~CLK;

    typedef enum int {EV_VALID, EV_PAR, EV_STP} ev_t;
    typedef struct {
        ev_t           kind;
        logic [DW-1:0] data;
        int            cycle;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            cyc       = 0;
    logic [DW-1:0] last_good = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int flag_code(input ev_t k);
        case (k)
            EV_VALID: return 4;
            EV_PAR:   return 2;
            default:  return 1;
        endcase
    endfunction

    // Reference model: outcome of a frame from what was put on the line.
    function automatic exp_t predict(input logic [DW-1:0] data, input bit pen, input bit ptyp,
                                     input logic par_bit, input logic stop_bit,
                                     input int glitch_bit, input int t0, input int p);
        exp_t e;
        logic [DW-1:0] rx;
        rx = data;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) rx[glitch_bit] = ~rx[glitch_bit];
`endif
        e.cycle = t0 + (pen ? 11 : 10) * p;
        e.data  = rx;
        if (!stop_bit)                          e.kind = EV_STP;
        else if (pen && (par_bit != (^rx ^ ptyp))) e.kind = EV_PAR;
        else                                    e.kind = EV_VALID;
        return e;
    endfunction

    // Monitor: compares every strobe against the head of the scoreboard.
    exp_t mon_e;
    always @(negedge CLK) begin
        if (RST) begin
            if (Data_Valid || Par_Err || Stp_Err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("strobe_cycle", cyc, mon_e.cycle);
                    check("strobe_flags", int'({Data_Valid, Par_Err, Stp_Err}), flag_code(mon_e.kind));
                    if (mon_e.kind == EV_VALID) last_good = mon_e.data;
                    check("p_data", int'(P_DATA), int'(last_good));
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].cycle) begin
                check("strobe_missing", 0, 1);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; cut >= 0 drives only the first cut cycles and predicts nothing.
    task automatic send_frame(input logic [DW-1:0] data, input int p, input bit pen, input bit ptyp,
                              input bit par_ok, input logic stop_bit, input int glitch_bit,
                              input int cut);
        logic bits[$];
        logic par_bit;
        logic v;
        int   n;
        int   t0;
        par_bit = par_ok ? (^data ^ ptyp) : ~(^data ^ ptyp);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        n = bits.size() * p;
        if (cut >= 0) n = cut;
        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
            if (c == 0) begin
                t0       = cyc;
                Prescale = 6'(p);
                PAR_EN   = pen;
                PAR_TYP  = ptyp;
                if (cut < 0) sb_q.push_back(predict(data, pen, ptyp, par_bit, stop_bit, glitch_bit, t0, p));
            end else if (c == 1) begin
                // Mid-frame config changes must be ignored by the receiver.
                Prescale = (p == 8) ? 6'd32 : 6'd8;
                PAR_EN   = ~pen;
                PAR_TYP  = ~ptyp;
            end
            v = bits[c / p];
            if (glitch_bit >= 0 && (c / p) == glitch_bit + 1 && (c % p) == p / 2) v = ~v;
            RX_IN = v;
        end
    endtask

    // Short low pulse that must be rejected; line is released just in time for
    // a frame to start at the latest legal return-to-idle cycle.
    task automatic send_start_glitch(input int p, input int g);
        for (int c = 0; c < p / 2 + 2; c++) begin
            @(posedge CLK); #1;
            if (c == 0) Prescale = 6'(p);
            RX_IN = (c < g) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int            r_p, r_gb;
    bit            r_pen, r_ptyp, r_pok;
    logic          r_stop;
    logic [DW-1:0] r_data;

    initial begin
        // Reset state
        #2;
        check("reset_p_data", int'(P_DATA), 0);
        check("reset_valid", int'(Data_Valid), 0);
        check("reset_par_err", int'(Par_Err), 0);
        check("reset_stp_err", int'(Stp_Err), 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        idle(4);

        // Parity frame, even parity
        send_frame(8'hA5, 8, 1, 0, 1, 1'b1, -1, -1);
        idle(3);
        // Back-to-back frames without parity
        send_frame(8'h3C, 16, 0, 0, 1, 1'b1, -1, -1);
        send_frame(8'hC3, 16, 0, 0, 1, 1'b1, -1, -1);
        idle(2);

        // Reset mid-frame, one cycle before the strobe would fire
        send_frame(8'h5A, 8, 1, 0, 1, 1'b1, -1, 11 * 8 - 1);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("midrst_p_data", int'(P_DATA), 0);
        check("midrst_valid", int'(Data_Valid), 0);
        check("midrst_par_err", int'(Par_Err), 0);
        check("midrst_stp_err", int'(Stp_Err), 0);
        last_good = '0;
        @(posedge CLK); #1;
        RX_IN = 1'b1;
        RST   = 1'b1;
        idle(3);

        // Wrong parity with odd parity selected
        send_frame(8'h01, 8, 1, 1, 0, 1'b1, -1, -1);
        idle(2);
        // Stop bit forced low
        send_frame(8'h55, 32, 0, 0, 1, 1'b0, -1, -1);
        idle(2);
        // Start glitch followed immediately by a valid frame
        send_start_glitch(8, 2);
        send_frame(8'h7E, 8, 0, 0, 1, 1'b1, -1, -1);
        idle(2);
        // Mid-bit glitch on data bit 0
        send_frame(8'h00, 8, 0, 0, 1, 1'b1, 0, -1);
        idle(2);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            r_p    = 8 << $urandom_range(0, 2);
            r_pen  = 1'($urandom_range(0, 1));
            r_ptyp = 1'($urandom_range(0, 1));
            r_pok  = ($urandom_range(0, 4) != 0);
            r_stop = ($urandom_range(0, 5) != 0);
            r_gb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            r_data = DW'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) send_start_glitch(r_p, int'($urandom_range(1, r_p / 2 - 2)));
            send_frame(r_data, r_p, r_pen, r_ptyp, r_pok, r_stop, r_gb, -1);
            idle(int'($urandom_range(0, 3)));
        end

        idle(2);
        for (int k = 0; k < 2000 && sb_q.size() != 0; k++) @(posedge CLK);
        idle(4);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
